// File: rtl/data_sched_pkg.sv
// Shared types and defaults for the data block scheduler.
package data_sched_pkg;

  localparam int DEF_ID_W    = 4;
  localparam int DEF_DIM_W   = 8;
  localparam int DEF_TIMEOUT = 4096;
  localparam int WD_W        = $clog2(DEF_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/sched_watchdog.sv
// WAIT-phase watchdog: counts enabled cycles and flags the TIMEOUT-th one.
module sched_watchdog
  import data_sched_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // The count equals the number of WAIT cycles already spent, so the
  // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
  assign expired_o = (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/data_block_scheduler.sv
// Sweeps input IDs of one layer: waits for PE readiness, pulses input_prepare,
// waits for loop_finished, with watchdog timeout and abort.
module data_block_scheduler
  import data_sched_pkg::*;
#(
  parameter int ID_W    = DEF_ID_W,
  parameter int DIM_W   = DEF_DIM_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ID_W-1:0]  num_inputs_i,
  input  logic [DIM_W-1:0] block_width_i,
  input  logic [DIM_W-1:0] block_height_i,
  input  logic             size_type_i,
  input  logic             pe_ready_i,
  input  logic             loop_finished_i,
  output logic [ID_W-1:0]  input_id_o,
  output logic             input_prepare_o,
  output logic [DIM_W-1:0] block_width_o,
  output logic [DIM_W-1:0] block_height_o,
  output logic             size_type_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ID_W:0]    ids_done_o,
  output logic             timeout_err_o,
  output logic             cfg_err_o,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: pe_ready_i is a level qualifying the ISSUE cycle; input_prepare_o
  // and done_o are one-cycle registered pulses; loop_finished_i counts only in
  // WAIT cycles other than the one carrying input_prepare_o.

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  num_q;
  logic [ID_W-1:0]  input_id_q;
  logic [DIM_W-1:0] block_width_q;
  logic [DIM_W-1:0] block_height_q;
  logic             size_type_q;
  logic             input_prepare_q;
  logic             busy_q;
  logic             done_q;
  logic [ID_W:0]    ids_done_q;
  logic             timeout_err_q;
  logic             cfg_err_q;

  logic wd_expired;
  logic start_accept;
  logic cfg_bad;
  logic finish_take;
  logic timeout_hit;
  logic id_advance;

  sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != S_WAIT),
    .enable_i  (state_q == S_WAIT),
    .expired_o (wd_expired)
  );

  assign cfg_bad      = (block_width_i == '0) || (block_height_i == '0);
  assign start_accept = (state_q == S_IDLE) && start_i && !abort_i;
  assign finish_take  = (state_q == S_WAIT) && loop_finished_i && !input_prepare_q && !abort_i;
  assign timeout_hit  = (state_q == S_WAIT) && !finish_take && wd_expired && !abort_i;
  assign id_advance   = (state_q == S_NEXT) && (state_d == S_ISSUE);

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_bad || (num_inputs_i == '0)) state_d = S_DONE;
            else                                 state_d = S_ISSUE;
          end
        end
        S_ISSUE: if (pe_ready_i) state_d = S_WAIT;
        S_WAIT: begin
          if (finish_take)      state_d = S_NEXT;
          else if (wd_expired)  state_d = S_DONE;
        end
        S_NEXT: begin
          if (input_id_q == num_q - ID_W'(1)) state_d = S_DONE;
          else                                state_d = S_ISSUE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      num_q           <= '0;
      input_id_q      <= '0;
      block_width_q   <= '0;
      block_height_q  <= '0;
      size_type_q     <= 1'b0;
      input_prepare_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      ids_done_q      <= '0;
      timeout_err_q   <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= (state_d != S_IDLE);
      input_prepare_q <= (state_q == S_ISSUE) && pe_ready_i && !abort_i;
      done_q          <= (state_q == S_DONE) && !abort_i;

      if (start_accept) begin
        num_q          <= num_inputs_i;
        block_width_q  <= block_width_i;
        block_height_q <= block_height_i;
        size_type_q    <= size_type_i;
        input_id_q     <= '0;
        ids_done_q     <= '0;
        timeout_err_q  <= 1'b0;
        cfg_err_q      <= cfg_bad;
      end

      if (finish_take) ids_done_q <= ids_done_q + (ID_W+1)'(1);
      if (timeout_hit) timeout_err_q <= 1'b1;
      if (id_advance)  input_id_q <= input_id_q + ID_W'(1);
    end
  end

  assign input_id_o      = input_id_q;
  assign input_prepare_o = input_prepare_q;
  assign block_width_o   = block_width_q;
  assign block_height_o  = block_height_q;
  assign size_type_o     = size_type_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign ids_done_o      = ids_done_q;
  assign timeout_err_o   = timeout_err_q;
  assign cfg_err_o       = cfg_err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_data_block_scheduler.sv
// Self-checking bench for data_block_scheduler with a timeline reference model.
module tb_data_block_scheduler;

  localparam int ID_W    = 4;
  localparam int DIM_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [ID_W-1:0]  num_inputs_i = '0;
  logic [DIM_W-1:0] block_width_i = '0;
  logic [DIM_W-1:0] block_height_i = '0;
  logic             size_type_i = 1'b0;
  logic             pe_ready_i = 1'b0;
  logic             loop_finished_i = 1'b0;
  logic [ID_W-1:0]  input_id_o;
  logic             input_prepare_o;
  logic [DIM_W-1:0] block_width_o;
  logic [DIM_W-1:0] block_height_o;
  logic             size_type_o;
  logic             busy_o;
  logic             done_o;
  logic [ID_W:0]    ids_done_o;
  logic             timeout_err_o;
  logic             cfg_err_o;
  logic [2:0]       dbg_state_o;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // event log sampled on the falling edge
  int prep_cyc_q[$];
  logic [ID_W-1:0] prep_id_q[$];
  int done_cyc_q[$];

  data_block_scheduler #(
    .ID_W    (ID_W),
    .DIM_W   (DIM_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .num_inputs_i    (num_inputs_i),
    .block_width_i   (block_width_i),
    .block_height_i  (block_height_i),
    .size_type_i     (size_type_i),
    .pe_ready_i      (pe_ready_i),
    .loop_finished_i (loop_finished_i),
    .input_id_o      (input_id_o),
    .input_prepare_o (input_prepare_o),
    .block_width_o   (block_width_o),
    .block_height_o  (block_height_o),
    .size_type_o     (size_type_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ids_done_o      (ids_done_o),
    .timeout_err_o   (timeout_err_o),
    .cfg_err_o       (cfg_err_o),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (input_prepare_o) begin
        prep_cyc_q.push_back(cyc);
        prep_id_q.push_back(input_id_o);
      end
      if (done_o) done_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    prep_cyc_q.delete();
    prep_id_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic start_sweep(input int num, input int w, input int h, input bit st,
                             output int s);
    num_inputs_i   = ID_W'(num);
    block_width_i  = DIM_W'(w);
    block_height_i = DIM_W'(h);
    size_type_i    = st;
    start_i        = 1'b1;
    s              = cyc;
    tick();
    start_i        = 1'b0;
    num_inputs_i   = ID_W'($urandom);
    block_width_i  = DIM_W'($urandom);
    block_height_i = DIM_W'($urandom);
    size_type_i    = 1'($urandom);
  endtask

  task automatic pulse_finish(output int f);
    loop_finished_i = 1'b1;
    f = cyc;
    tick();
    loop_finished_i = 1'b0;
  endtask

  task automatic wait_prep(output int pc, output bit ok);
    ok = 1'b0;
    pc = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (input_prepare_o) begin
        ok = 1'b1;
        pc = cyc;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_prep no input_prepare_o within 40 cycles");
    end
  endtask

  task automatic wait_done(output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (done_o) begin
        ok = 1'b1;
        dc = cyc;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_done no done_o within 40 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_i = 1'b1;
    num_inputs_i = 4'd5;
    block_width_i = 8'd3;
    block_height_i = 8'd3;
    pe_ready_i = 1'b1;
    repeat (3) tick();
    start_i = 1'b0;
    checks++;
    if ({input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o} !== '0)
      $display("FAIL reset_cfg got id=%0d prep=%0b w=%0d h=%0d st=%0b want all 0",
               input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o);
    else passed++;
    checks++;
    if ({busy_o, done_o, ids_done_o, timeout_err_o, cfg_err_o} !== '0)
      $display("FAIL reset_status got busy=%0b done=%0b ids=%0d to=%0b cfg=%0b want all 0",
               busy_o, done_o, ids_done_o, timeout_err_o, cfg_err_o);
    else passed++;
    checks++;
    if (dbg_state_o !== 3'(data_sched_pkg::S_IDLE))
      $display("FAIL reset_state got %0d want IDLE", dbg_state_o);
    else passed++;
    reset = 1'b1;
    tick();
  endtask

  // Reference timeline: first prepare 2 cycles after start, each later prepare
  // 3 cycles after the finish that precedes it, done_o 3 cycles after last finish.
  task automatic run_sweep(input int num, input int fixed_d, input string tag);
    int s, pc, f, dc, d, w, h;
    bit ok, st;
    logic [ID_W:0] exp_done;
    w  = $urandom_range(1, 255);
    h  = $urandom_range(1, 255);
    st = 1'($urandom);
    f  = 0;
    clear_log();
    pe_ready_i = 1'b1;
    start_sweep(num, w, h, st, s);
    for (int i = 0; i < num; i++) begin
      wait_prep(pc, ok);
      if (!ok) return;
      checks++;
      if (pc !== ((i == 0) ? s + 2 : f + 3))
        $display("FAIL %s prep_cycle id%0d got %0d want %0d", tag, i, pc, (i == 0) ? s + 2 : f + 3);
      else passed++;
      checks++;
      if (input_id_o !== ID_W'(i))
        $display("FAIL %s prep_id got %0d want %0d", tag, input_id_o, i);
      else passed++;
      d = (fixed_d != 0) ? fixed_d : $urandom_range(1, 6);
      repeat (d) tick();
      pulse_finish(f);
      exp_done = (ID_W+1)'(i + 1);
      checks++;
      if (ids_done_o !== exp_done)
        $display("FAIL %s ids_done got %0d want %0d", tag, ids_done_o, exp_done);
      else passed++;
    end
    wait_done(dc, ok);
    if (!ok) return;
    checks++;
    if (dc !== f + 3) $display("FAIL %s done_cycle got %0d want %0d", tag, dc, f + 3);
    else passed++;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL %s busy_after got %0b want 0", tag, busy_o);
    else passed++;
    checks++;
    if ({block_width_o, block_height_o, size_type_o} !== {DIM_W'(w), DIM_W'(h), st})
      $display("FAIL %s latched_cfg got w=%0d h=%0d st=%0b want w=%0d h=%0d st=%0b",
               tag, block_width_o, block_height_o, size_type_o, w, h, st);
    else passed++;
    checks++;
    if ({timeout_err_o, cfg_err_o} !== 2'b00)
      $display("FAIL %s errors got to=%0b cfg=%0b want 0", tag, timeout_err_o, cfg_err_o);
    else passed++;
    tick();
    tick();
    checks++;
    if (prep_cyc_q.size() !== num || done_cyc_q.size() !== 1)
      $display("FAIL %s event_count got prep=%0d done=%0d want prep=%0d done=1",
               tag, prep_cyc_q.size(), done_cyc_q.size(), num);
    else passed++;
  endtask

  task automatic test_sweep();
    run_sweep(3, 5, "sweep3");
    for (int r = 0; r < 3; r++) run_sweep($urandom_range(1, 5), 0, "sweep_rand");
  endtask

  task automatic test_empty();
    int s, dc;
    bit ok;
    clear_log();
    pe_ready_i = 1'b1;
    start_sweep(0, 4, 4, 1'b0, s);
    wait_done(dc, ok);
    if (ok) begin
      checks++;
      if (dc !== s + 2) $display("FAIL empty_done got %0d want %0d", dc, s + 2);
      else passed++;
    end
    checks++;
    if (prep_cyc_q.size() !== 0 || ids_done_o !== '0 || cfg_err_o !== 1'b0)
      $display("FAIL empty_side prep=%0d ids=%0d cfg=%0b want 0 0 0",
               prep_cyc_q.size(), ids_done_o, cfg_err_o);
    else passed++;
    tick();
    clear_log();
    start_sweep(2, 0, 4, 1'b0, s);
    checks++;
    if (cfg_err_o !== 1'b1) $display("FAIL cfg_err got %0b want 1", cfg_err_o);
    else passed++;
    wait_done(dc, ok);
    if (ok) begin
      checks++;
      if (dc !== s + 2) $display("FAIL cfg_done got %0d want %0d", dc, s + 2);
      else passed++;
    end
    tick();
    checks++;
    if (prep_cyc_q.size() !== 0 || cfg_err_o !== 1'b1)
      $display("FAIL cfg_side prep=%0d cfg=%0b want 0 1", prep_cyc_q.size(), cfg_err_o);
    else passed++;
  endtask

  task automatic test_pe_ready();
    int s, r, f, dc;
    bit ok;
    clear_log();
    pe_ready_i = 1'b0;
    start_sweep(1, 2, 2, 1'b1, s);
    repeat (10) tick();
    checks++;
    if (prep_cyc_q.size() !== 0 || busy_o !== 1'b1)
      $display("FAIL ready_low prep=%0d busy=%0b want 0 1", prep_cyc_q.size(), busy_o);
    else passed++;
    pe_ready_i = 1'b1;
    r = cyc;
    tick();
    checks++;
    if (input_prepare_o !== 1'b1) $display("FAIL ready_prep got %0b want 1 at %0d", input_prepare_o, r + 1);
    else passed++;
    tick();
    checks++;
    if (input_prepare_o !== 1'b0) $display("FAIL ready_single got %0b want 0", input_prepare_o);
    else passed++;
    pulse_finish(f);
    wait_done(dc, ok);
    tick();
    checks++;
    if (prep_cyc_q.size() !== 1) $display("FAIL ready_count got %0d want 1", prep_cyc_q.size());
    else passed++;
  endtask

  task automatic test_timeout();
    int s, pc, t, dc, f;
    bit ok;
    clear_log();
    pe_ready_i = 1'b1;
    start_sweep(2, 5, 5, 1'b0, s);
    wait_prep(pc, ok);
    if (!ok) return;
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      tick();
      if (timeout_err_o) t = cyc;
    end
    checks++;
    if (t !== pc + TIMEOUT) $display("FAIL timeout_cycle got %0d want %0d", t, pc + TIMEOUT);
    else passed++;
    tick();
    checks++;
    if (done_o !== 1'b1 || ids_done_o !== '0)
      $display("FAIL timeout_done done=%0b ids=%0d want 1 0", done_o, ids_done_o);
    else passed++;
    tick();
    start_sweep(1, 1, 1, 1'b0, s);
    checks++;
    if (timeout_err_o !== 1'b0) $display("FAIL timeout_clear got %0b want 0", timeout_err_o);
    else passed++;
    wait_prep(pc, ok);
    pulse_finish(f);
    wait_done(dc, ok);
    tick();
  endtask

  task automatic test_abort();
    int s, pc, f;
    bit ok;
    clear_log();
    pe_ready_i = 1'b1;
    start_sweep(3, 17, 9, 1'b1, s);
    wait_prep(pc, ok);
    if (!ok) return;
    tick();
    pulse_finish(f);
    wait_prep(pc, ok);
    if (!ok) return;
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL abort_idle busy=%0b done=%0b want 0 0", busy_o, done_o);
    else passed++;
    pulse_finish(f);
    repeat (3) tick();
    checks++;
    if (ids_done_o !== 5'd1) $display("FAIL abort_late_finish ids=%0d want 1", ids_done_o);
    else passed++;
    checks++;
    if (done_cyc_q.size() !== 0 || prep_cyc_q.size() !== 2 || busy_o !== 1'b0)
      $display("FAIL abort_events done=%0d prep=%0d busy=%0b want 0 2 0",
               done_cyc_q.size(), prep_cyc_q.size(), busy_o);
    else passed++;
    checks++;
    if ({block_width_o, block_height_o, size_type_o} !== {8'd17, 8'd9, 1'b1})
      $display("FAIL abort_cfg w=%0d h=%0d st=%0b want 17 9 1", block_width_o, block_height_o, size_type_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int s, pc, f, dc;
    bit ok;
    clear_log();
    pe_ready_i = 1'b1;
    start_sweep(2, 33, 44, 1'b0, s);
    wait_prep(pc, ok);
    if (!ok) return;
    tick();
    num_inputs_i  = 4'd9;
    block_width_i = 8'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || block_width_o !== 8'd33 || input_id_o !== 4'd0)
      $display("FAIL extra_start busy=%0b w=%0d id=%0d want 1 33 0", busy_o, block_width_o, input_id_o);
    else passed++;
    tick();
    pulse_finish(f);
    wait_prep(pc, ok);
    if (!ok) return;
    checks++;
    if (pc !== f + 3) $display("FAIL b2b_prep got %0d want %0d", pc, f + 3);
    else passed++;
    pulse_finish(f);
    repeat (3) tick();
    checks++;
    if (ids_done_o !== 5'd1 || done_cyc_q.size() !== 0 || busy_o !== 1'b1)
      $display("FAIL prep_cycle_finish ids=%0d done=%0d busy=%0b want 1 0 1",
               ids_done_o, done_cyc_q.size(), busy_o);
    else passed++;
    pulse_finish(f);
    wait_done(dc, ok);
    if (ok) begin
      checks++;
      if (dc !== f + 3 || ids_done_o !== 5'd2)
        $display("FAIL b2b_done cyc=%0d ids=%0d want %0d 2", dc, ids_done_o, f + 3);
      else passed++;
    end
    tick();
    start_sweep(3, 7, 7, 1'b1, s);
    wait_prep(pc, ok);
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({input_id_o, input_prepare_o, block_width_o, block_height_o, size_type_o, busy_o,
         done_o, ids_done_o, timeout_err_o, cfg_err_o} !== '0)
      $display("FAIL midsweep_reset busy=%0b w=%0d ids=%0d want all 0", busy_o, block_width_o, ids_done_o);
    else passed++;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_empty();
    test_pe_ready();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
